mc_alu: RTL
===========

Name: mc_alu

Overview:
- Parametrised multi-cycle successor to the datapath ALU.
- Single-cycle ops: logic, add/sub, shift, compare; result registered, 1-cycle latency.
- Iterative ops: radix-2 shift-add multiply and restoring divide, both producing full double-width results.
- Sits between the register-read stage and writeback; the control unit issues `start` and stalls on `busy`.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 8, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue request; accepted only when busy=0.
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- shamt  in  SHW  shift amount.
- busy  out  1  high from accept until the cycle done is asserted.
- done  out  1  one-cycle pulse; result fields valid from this cycle.
- result  out  WIDTH  primary result (low product / quotient).
- result_hi  out  WIDTH  high product / remainder; 0 for other ops.
- zero  out  1  result==0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow (add, sub, signed div MIN/-1).
- carry  out  1  unsigned carry-out (addu) / borrow (subu).
- div_by_zero  out  1  divide issued with b==0.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: busy, done, result, result_hi, all flags.
  - Any in-flight op is abandoned; nothing is emitted after release.
- Op codes:
  - 0000 add
  - 0001 sub
  - 0010 mul signed
  - 0011 div signed
  - 0100 sll
  - 0101 srl
  - 0110 addu
  - 0111 subu
  - 1000 and
  - 1001 or
  - 1010 xor
  - 1011 nor
  - 1100 sra
  - 1101 slt signed
  - 1110 sltu
  - 1111 divu
- Accept: start=1 while IDLE. Operands and op are latched that edge; start while busy=1 is ignored (no queueing).
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE: single-cycle op -> FIN. mul -> MUL. div/divu with b!=0 -> DIV. div/divu with b==0 -> FIN.
  - MUL: WIDTH iterations, counter counts 0..WIDTH-1, then -> FIN.
  - DIV: WIDTH iterations, counter counts 0..WIDTH-1, then -> FIN.
  - FIN: done=1 for one cycle, busy=0, -> IDLE.
- busy=1 in MUL and DIV, and in the cycle after accept.
- Latency (accept edge to done): single-cycle and div-by-zero = 1 clk; mul/div = WIDTH+1 clk. Back-to-back issue is allowed in the FIN cycle.
- Output hold: result and flags hold their values until the next done.
- Arithmetic:
  - Signed mul/div: operate on magnitudes, then negate per operand signs.
  - Remainder takes the sign of a.
- Divide boundary cases:
  - b==0: result = all ones, result_hi = a, div_by_zero=1.
  - Signed MIN/-1: result = MIN, result_hi = 0, overflow=1.
- Flag rules:
  - add/sub overflow: standard sign rule.
  - carry: valid only for addu/subu, 0 otherwise.
  - overflow: 0 for logic and shift ops.
  - mul overflow: set when the signed product does not fit in WIDTH bits.
- Shifts: use shamt and ignore b. sra replicates a[WIDTH-1].
- Compares: slt/sltu produce 0 or 1 in bit 0.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: mul is combinational and registered in one cycle; latency 1, MUL state unused.
- Undefined: iterative shift-add multiply, latency WIDTH+1.
- Results are identical either way.

Decomposition:
- Package mc_alu_pkg holds:
  - op code localparams (OP_ADD..OP_DIVU)
  - state encoding typedef (IDLE/MUL/DIV/FIN)
  - helper function for the signed-overflow rule
- Sub-module mc_alu_divider: iterative unsigned restoring divider with its own counter. Interface: start/done, dividend, divisor, quotient, remainder. Sign handling stays in mc_alu.

Test Plan:
- Reset mid-divide: issue div 100/7, assert rst_n=0 at iteration 10 -> all outputs 0 immediately; no done after release.
- add 0x7FFFFFFF+1 -> done 1 clk later, result=0x80000000, overflow=1, negative=1. addu 0xFFFFFFFF+1 -> result=0, carry=1, zero=1.
- mul -3 * 5 -> done at cycle 33, {result_hi,result} = 0xFFFFFFFF_FFFFFFF1. With ALU_FAST_MUL_EN -> same value at cycle 1.
- div -7/2 -> result=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). divu 7/0 -> cycle 1, result=0xFFFFFFFF, result_hi=7, div_by_zero=1.
- div 0x80000000 / 0xFFFFFFFF -> result=0x80000000, result_hi=0, overflow=1.
- start held high during divu 1000/10 -> only one done (cycle 33), result=100. A second op issued in the FIN cycle completes correctly. sra 0x80000000 by 4 -> 0xF8000000.

Source files
------------

// File: rtl/mc_alu_pkg.sv
// Shared definitions for mc_alu: op codes, FSM state encoding, flag struct and
// the signed-overflow rule.
package mc_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_ADDU = 4'b0110;
  localparam logic [3:0] OP_SUBU = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic div_by_zero;
  } alu_flags_t;

  // Overflow of sa + sb -> sr; for subtraction pass the inverted sign of b.
  function automatic logic sovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/mc_alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// done is high during the final iteration; quotient/remainder are valid while done=1.
module mc_alu_divider
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH:0]   shifted, diff;

  // diff[WIDTH] set means the trial subtraction borrowed: restore.
  assign shifted   = {r, q[WIDTH-1]};
  assign diff      = shifted - {1'b0, d};
  assign quotient  = {q[WIDTH-2:0], ~diff[WIDTH]};
  assign remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign done      = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      d   <= '0;
    end else if (start && !run) begin
      run <= 1'b1;
      cnt <= '0;
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
    end else if (run) begin
      q   <= quotient;
      r   <= remainder;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: registered single-cycle ops, iterative mul/div on magnitudes.
// Define ALU_FAST_MUL_EN to make mul single-cycle (combinational product).
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic             accept, is_mul, is_div, div_sgn, mul_iter, b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum_u, dif_u;
  logic [WIDTH-1:0] imm_lo, imm_hi, wr_lo, wr_hi;
  alu_flags_t       imm_flg, wr_flg;
  logic             wr_en;
  logic             neg_q, rem_neg_q, div_ovf_q;
  logic             div_done;
  logic [WIDTH-1:0] quo, rem, q_fix, r_fix;

  assign is_mul  = (op == OP_MUL);
  assign div_sgn = (op == OP_DIV);
  assign is_div  = div_sgn || (op == OP_DIVU);
  assign b_zero  = (b == '0);
  assign accept  = start && ((state == IDLE) || (state == FIN));
  assign a_neg   = a[WIDTH-1] && (is_mul || div_sgn);
  assign b_neg   = b[WIDTH-1] && (is_mul || div_sgn);
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign sum_u   = {1'b0, a} + {1'b0, b};
  assign dif_u   = {1'b0, a} - {1'b0, b};

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == FIN);

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fprod;
  assign fprod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign mul_iter = 1'b0;
`else
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH:0]     psum;
  logic [SHW-1:0]     cnt;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_iter = is_mul;
  assign psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
  assign acc_nxt  = {psum, acc[WIDTH-1:1]};
  assign prod     = neg_q ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept && is_mul) begin
      mcand <= a_mag;
      acc   <= {{WIDTH{1'b0}}, b_mag};
      cnt   <= '0;
    end else if (state == MUL) begin
      acc   <= acc_nxt;
      cnt   <= cnt + 1'b1;
    end
  end
`endif

  mc_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_div && !b_zero),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = rem_neg_q ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div_ovf_q <= 1'b0;
    end else if (accept) begin
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      div_ovf_q <= div_sgn && (a == MIN) && (b == '1);
    end
  end

  // Results for everything that completes on the accept edge.
  always_comb begin
    imm_lo  = '0;
    imm_hi  = '0;
    imm_flg = '0;
    case (op)
      OP_ADD: begin
        imm_lo           = sum_u[WIDTH-1:0];
        imm_flg.overflow = sovf(a[WIDTH-1], b[WIDTH-1], sum_u[WIDTH-1]);
      end
      OP_SUB: begin
        imm_lo           = dif_u[WIDTH-1:0];
        imm_flg.overflow = sovf(a[WIDTH-1], ~b[WIDTH-1], dif_u[WIDTH-1]);
      end
      OP_ADDU: begin
        imm_lo        = sum_u[WIDTH-1:0];
        imm_flg.carry = sum_u[WIDTH];
      end
      OP_SUBU: begin
        imm_lo        = dif_u[WIDTH-1:0];
        imm_flg.carry = dif_u[WIDTH];
      end
      OP_SLL:  imm_lo = a << shamt;
      OP_SRL:  imm_lo = a >> shamt;
      OP_SRA:  imm_lo = $signed(a) >>> shamt;
      OP_AND:  imm_lo = a & b;
      OP_OR:   imm_lo = a | b;
      OP_XOR:  imm_lo = a ^ b;
      OP_NOR:  imm_lo = ~(a | b);
      OP_SLT:  imm_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: imm_lo = {{(WIDTH-1){1'b0}}, a < b};
      OP_DIV, OP_DIVU: begin
        imm_lo              = '1;
        imm_hi              = a;
        imm_flg.div_by_zero = 1'b1;
      end
      OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
        imm_lo           = fprod[WIDTH-1:0];
        imm_hi           = fprod[2*WIDTH-1:WIDTH];
        imm_flg.overflow = fprod[2*WIDTH-1:WIDTH] != {WIDTH{fprod[WIDTH-1]}};
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_lo     = imm_lo;
    wr_hi     = imm_hi;
    wr_flg    = imm_flg;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (accept) begin
          if (mul_iter)               state_nxt = MUL;
          else if (is_div && !b_zero) state_nxt = DIV;
          else begin
            state_nxt = FIN;
            wr_en     = 1'b1;
          end
        end
      end
`ifndef ALU_FAST_MUL_EN
      MUL: if (cnt == SHW'(WIDTH - 1)) begin
        state_nxt       = FIN;
        wr_en           = 1'b1;
        wr_lo           = prod[WIDTH-1:0];
        wr_hi           = prod[2*WIDTH-1:WIDTH];
        wr_flg          = '0;
        wr_flg.overflow = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
      end
`endif
      DIV: if (div_done) begin
        state_nxt       = FIN;
        wr_en           = 1'b1;
        wr_lo           = q_fix;
        wr_hi           = r_fix;
        wr_flg          = '0;
        wr_flg.overflow = div_ovf_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs only move on a completion, so they hold between dones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (wr_en) begin
      result      <= wr_lo;
      result_hi   <= wr_hi;
      zero        <= (wr_lo == '0);
      negative    <= wr_lo[WIDTH-1];
      overflow    <= wr_flg.overflow;
      carry       <= wr_flg.carry;
      div_by_zero <= wr_flg.div_by_zero;
    end
  end

endmodule
